// File: rtl/mdu_if.sv
// E-stage multiply/divide bus: operation request from the pipeline and
// the HI/LO busy/read-back response from the unit.
interface mdu_if;
  logic [3:0]  E_MDUop;
  logic        E_start;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_HILObusy;
  logic [31:0] E_HILOout;

  modport master (
    output E_MDUop, E_start, E_A, E_B,
    input  E_HILObusy, E_HILOout
  );

  modport slave (
    input  E_MDUop, E_start, E_A, E_B,
    output E_HILObusy, E_HILOout
  );
endinterface

// File: rtl/mdu.sv
// Fixed-latency multiply/divide unit owning HI/LO. The result is computed at the
// start edge, then committed to HI/LO after a programmable countdown.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
  logic        busy_q, busy_d;
  logic        skip_q, skip_d;
  logic [3:0]  cnt_q, cnt_d;

  logic               b_zero;
  logic               is_md_op;
  logic signed [63:0] a_sx, b_sx, smul;
  logic        [63:0] umul;
  logic signed [32:0] dvd_s, dvs_s, squo, srem;
  logic        [31:0] dvs_u, uquo, urem;

  assign b_zero   = (bus.E_B == 32'd0);
  assign is_md_op = (bus.E_MDUop >= OP_MULT) && (bus.E_MDUop <= OP_DIVU);

  assign a_sx = {{32{bus.E_A[31]}}, bus.E_A};
  assign b_sx = {{32{bus.E_B[31]}}, bus.E_B};
  assign smul = a_sx * b_sx;
  assign umul = {32'd0, bus.E_A} * {32'd0, bus.E_B};

  // 33-bit signed divide so that 0x80000000 / -1 yields +2^31, whose low word is 0x80000000.
  assign dvd_s = {bus.E_A[31], bus.E_A};
  assign dvs_s = b_zero ? 33'sd1 : {bus.E_B[31], bus.E_B};
  assign squo  = dvd_s / dvs_s;
  assign srem  = dvd_s % dvs_s;

  assign dvs_u = b_zero ? 32'd1 : bus.E_B;
  assign uquo  = bus.E_A / dvs_u;
  assign urem  = bus.E_A % dvs_u;

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_n_d = hi_n_q;
    lo_n_d = lo_n_q;
    busy_d = busy_q;
    skip_d = skip_q;
    cnt_d  = cnt_q;
    if (busy_q) begin
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        cnt_d  = 4'd0;
        if (!skip_q) begin
          hi_d = hi_n_q;
          lo_d = lo_n_q;
        end
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end else if (bus.E_start && is_md_op) begin
      busy_d = 1'b1;
      skip_d = 1'b0;
      case (bus.E_MDUop)
        OP_MULT:  begin {hi_n_d, lo_n_d} = smul; cnt_d = MULT_N; end
        OP_MULTU: begin {hi_n_d, lo_n_d} = umul; cnt_d = MULT_N; end
        OP_DIV: begin
          hi_n_d = srem[31:0];
          lo_n_d = squo[31:0];
          skip_d = b_zero;
          cnt_d  = DIV_N;
        end
        OP_DIVU: begin
          hi_n_d = urem;
          lo_n_d = uquo;
          skip_d = b_zero;
          cnt_d  = DIV_N;
        end
        default: ;
      endcase
    end else if (bus.E_MDUop == OP_MTHI) begin
      hi_d = bus.E_A;
    end else if (bus.E_MDUop == OP_MTLO) begin
      lo_d = bus.E_A;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_n_q <= 32'd0;
      lo_n_q <= 32'd0;
      busy_q <= 1'b0;
      skip_q <= 1'b0;
      cnt_q  <= 4'd0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_n_q <= hi_n_d;
      lo_n_q <= lo_n_d;
      busy_q <= busy_d;
      skip_q <= skip_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.E_HILObusy = bus.E_start | busy_q;

  always_comb begin
    bus.E_HILOout = 32'd0;
    if (bus.E_MDUop == OP_MFHI)      bus.E_HILOout = hi_q;
    else if (bus.E_MDUop == OP_MFLO) bus.E_HILOout = lo_q;
  end

endmodule
